cordic_atan_seq: RTL



---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_atan_rom.sv | 9 +
 rtl/cordic_atan_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, FSM states and the arctan(2^-i) table in degrees, Q8.32.
package cordic_pkg;
   localparam int ANG_W = 40;
   localparam int OUT_W = 32;
   localparam int MAX_ITERS = 38;
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   localparam logic [ANG_W-1:0] ATAN [MAX_ITERS] = '{
      40'h2D_0000_0000, 40'h1A_90A7_31A6, 40'h0E_0947_407D, 40'h07_2001_1249,
      40'h03_938A_A64C, 40'h01_CA37_94E5, 40'h00_E52A_1AB1, 40'h00_7296_D7A1,
      40'h00_394B_A51B, 40'h00_1CA5_D9B7, 40'h00_0E52_EDC0, 40'h00_0729_76FD,
      40'h00_0394_BB82, 40'h00_01CA_5DC1, 40'h00_00E5_2EE0, 40'h00_0072_9770,
      40'h00_0039_4BB8, 40'h00_001C_A5DC, 40'h00_000E_52EE, 40'h00_0007_2977,
      40'h00_0003_94BB, 40'h00_0001_CA5D, 40'h00_0000_E52E, 40'h00_0000_7297,
      40'h00_0000_394B, 40'h00_0000_1CA5, 40'h00_0000_0E52, 40'h00_0000_0729,
      40'h00_0000_0394, 40'h00_0000_01CA, 40'h00_0000_00E5, 40'h00_0000_0072,
      40'h00_0000_0039, 40'h00_0000_001C, 40'h00_0000_000E, 40'h00_0000_0007,
      40'h00_0000_0003, 40'h00_0000_0001
   };
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational arctan(2^-i) lookup; indices past the table read zero.
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [5:0]       idx,
   output logic [ANG_W-1:0] atan
);
   assign atan = (idx < 6'(MAX_ITERS)) ? ATAN[idx] : '0;
endmodule

// File: rtl/cordic_atan_seq.sv
// cordic_atan_seq: sequential CORDIC vectoring arctangent, one micro-rotation per clock.
module cordic_atan_seq
   import cordic_pkg::*;
#(
   parameter int ITERS = 38
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inx,
   input  logic [31:0]      iny,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out,
   output logic             err,
   output logic             busy
);
   state_t                  state;
   logic signed [ANG_W-1:0] x, y, z, sx, sy, x_n, y_n, z_n;
   logic        [ANG_W-1:0] atan_i;
   logic        [5:0]       idx;

   cordic_atan_rom rom (.idx(idx), .atan(atan_i));

   // y >= 0 rotates clockwise, driving y toward zero while z accumulates the angle
   always_comb begin
      sx  = x >>> idx;
      sy  = y >>> idx;
      x_n = y[ANG_W-1] ? x - sy : x + sy;
      y_n = y[ANG_W-1] ? y + sx : y - sx;
      z_n = y[ANG_W-1] ? z - $signed(atan_i) : z + $signed(atan_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out       <= '0;
         err       <= 1'b0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid && in_ready) begin
               in_ready <= 1'b0;
               if (inx[31] || inx == '0) begin
                  out   <= '0;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  x     <= {{(ANG_W-32){inx[31]}}, inx};
                  y     <= {{(ANG_W-32){iny[31]}}, iny};
                  z     <= '0;
                  idx   <= '0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= ITER;
               end
            end
            ITER: begin
               x   <= x_n;
               y   <= y_n;
               z   <= z_n;
               idx <= idx + 6'd1;
               if (idx == 6'(ITERS-1)) begin
                  out       <= z_n[ANG_W-1:ANG_W-OUT_W];
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // the error path enters here with out_valid low and raises it one edge later
               if (!out_valid) out_valid <= 1'b1;
               else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
